// File: rtl/apb_sram.sv
// APB (v2) slave around a word-organised single-port SRAM.
// The read is captured on the setup edge so that PRDATA is already valid in the access phase.
// Writes commit on the access edge. Every transfer therefore completes with zero wait states.
module apb_sram #(
  parameter int unsigned SIZE_IN_BYTES = 1024
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA
);

  localparam int unsigned Depth = SIZE_IN_BYTES / 4;
  localparam int unsigned AW    = $clog2(Depth);
  localparam int unsigned IdxW  = (AW == 0) ? 1 : AW;

  logic [31:0]     mem [0:Depth-1];
  logic [31:0]     prdata_q;
  logic [IdxW-1:0] idx;
  logic            wr_en;
  logic            rd_en;
  logic            unused_paddr;

  // Upper address bits are ignored, so out-of-range addresses alias modulo the size.
  // Bits [1:0] are also ignored because only full words are accessed.
  generate
    if (AW == 0) begin : g_one_word
      assign idx = '0;
    end else begin : g_multi_word
      assign idx = PADDR[AW+1:2];
    end
  endgenerate

  assign unused_paddr = ^PADDR;

  assign wr_en = PSEL & PENABLE & PWRITE;
  assign rd_en = PSEL & ~PENABLE & ~PWRITE;

  // Write port. It is kept free of the async reset so that the array still infers as RAM.
  // The reset level gates the write, so an access edge that lands in reset is dropped.
  always_ff @(posedge PCLK) begin
    if (PRESETn && wr_en) begin
      mem[idx] <= PWDATA;
    end
  end

  // Registered read port. It loads only on a read setup edge and holds its value otherwise.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_q <= 32'h0;
    end else if (rd_en) begin
      prdata_q <= mem[idx];
    end
  end

  assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_sram.sv
// Randomised scoreboard bench for apb_sram.
// The driver pushes expected read data from an address-keyed reference memory.
// A monitor pops and compares at the access-end edge of every read.
module tb_apb_sram;

  localparam int unsigned Size  = 1024;
  localparam int unsigned Depth = Size / 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  apb_sram #(.SIZE_IN_BYTES(Size)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PADDR   (PADDR),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % Depth);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Each transfer leaves the bus in its access phase, so consecutive calls run back-to-back.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    model[widx(a)] = d;
  endtask

  task automatic apb_read(input logic [31:0] a);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a; PWDATA = $urandom;
    exp_q.push_back(model[widx(a)]);
    last_rd = model[widx(a)];
    @(negedge PCLK);
    PENABLE = 1'b1;
  endtask

  task automatic bus_idle(input int n);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = $urandom; PWDATA = $urandom;
    repeat (n - 1) @(negedge PCLK);
  endtask

  // Monitor: a read completes at the edge that ends its access phase.
  always @(posedge PCLK) begin
    if (PRESETn === 1'b1 && PSEL === 1'b1 && PENABLE === 1'b1 && PWRITE === 1'b0) begin
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %h want no read pending", PRDATA);
      end else begin
        check("rd_data", PRDATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; last_rd = '0;

    repeat (5) begin
      @(posedge PCLK); #1;
      check("reset_prdata", PRDATA, 32'h0);
    end
    @(negedge PCLK) PRESETn = 1'b1;
    repeat (3) @(posedge PCLK);

    // Read-after-write on every word.
    for (int a = 0; a < int'(Depth); a++) begin
      d = $urandom;
      apb_write(32'(4 * a), d);
      apb_read(32'(4 * a));
    end
    bus_idle(2);

    // Write all, then read all, with distinct words.
    for (int a = 0; a < int'(Depth); a++) begin
      d = ($urandom & 32'hFFFF_FF00) | 32'(a);
      apb_write(32'(4 * a), d);
    end
    for (int a = 0; a < int'(Depth); a++) apb_read(32'(4 * a));
    bus_idle(2);

    // Aliasing.
    apb_write(32'h000, 32'hA5A5_0001);
    apb_read(32'h400);
    apb_read(32'h003);
    apb_write(32'h7FC, 32'h1234_5678);
    apb_read(32'h3FC);
    bus_idle(2);

    // Setup-only write cycle must be inert.
    apb_write(32'h010, 32'h0000_1010);
    bus_idle(1);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h010; PWDATA = 32'hDEAD_BEEF;
    bus_idle(2);
    apb_read(32'h010);
    bus_idle(1);

    // PENABLE without PSEL must be inert.
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h010; PWDATA = 32'hCAFE_F00D;
    repeat (2) @(negedge PCLK);
    PENABLE = 1'b0;
    apb_read(32'h010);
    bus_idle(1);

    // PRDATA holds across idle cycles and an intervening write.
    apb_read(32'h3FC);
    bus_idle(2);
    @(posedge PCLK); #1;
    check("hold_idle", PRDATA, last_rd);
    apb_write(32'h014, 32'h5555_AAAA);
    @(posedge PCLK); #1;
    check("hold_write", PRDATA, last_rd);
    bus_idle(2);
    check("hold_after_write", PRDATA, last_rd);

    // Async reset between the setup and access edges of a write.
    apb_write(32'h020, 32'h0BAD_0020);
    apb_read(32'h020);
    bus_idle(2);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h020; PWDATA = 32'hFFFF_0000;
    @(posedge PCLK);
    #2 PRESETn = 1'b0;
    #1 check("async_reset", PRDATA, 32'h0);
    @(negedge PCLK) PENABLE = 1'b1;
    @(posedge PCLK); #1;
    check("reset_access_edge", PRDATA, 32'h0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
    repeat (3) @(posedge PCLK);
    apb_read(32'h020);
    bus_idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
